// File: rtl/cw305_aes_seq_pkg.sv
// Shared types and defaults for the CW305 AES sequencer.
// Build option AES_SEQ_WATCHDOG_EN enables the RUN-state watchdog.
package cw305_aes_seq_pkg;

    localparam int AES_W           = 128;
    localparam int DEF_COUNT_WIDTH = 16;
    localparam int DEF_WDOG_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE
    } seq_state_e;

endpackage

// File: rtl/cw305_start_detect.sv
// Merges the register GO pulse with the rising edge of the
// synchronized usb_trigger level into a single start strobe.
module cw305_start_detect (
    input  logic crypto_clk,
    input  logic reset_i,
    input  logic go_reg,
    input  logic go_trig,
    output logic start
);

    logic go_trig_q;

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            go_trig_q <= 1'b0;
        end else begin
            go_trig_q <= go_trig;
        end
    end

    assign start = go_reg | (go_trig & ~go_trig_q);

endmodule

// File: rtl/cw305_aes_sequencer.sv
// Batch sequencer for the AES core in the crypto clock domain.
// Optional watchdog: define AES_SEQ_WATCHDOG_EN.
module cw305_aes_sequencer
    import cw305_aes_seq_pkg::*;
#(
    parameter int pCOUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int pWDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    input  logic                    go_reg_i,
    input  logic                    go_trig_i,
    input  logic [AES_W-1:0]        textin_i,
    input  logic [AES_W-1:0]        key_i,
    input  logic [pCOUNT_WIDTH-1:0] batch_count_i,
    input  logic                    chain_i,
    output logic                    core_load_o,
    output logic [AES_W-1:0]        core_pt_o,
    output logic [AES_W-1:0]        core_key_o,
    input  logic                    core_done_i,
    input  logic [AES_W-1:0]        core_ct_i,
    output logic [AES_W-1:0]        cipherout_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    trigger_o,
    output logic [pCOUNT_WIDTH-1:0] runs_o,
    output logic                    error_o
);

    seq_state_e state_q, state_d;

    logic [AES_W-1:0]        pt_q;
    logic [AES_W-1:0]        key_q;
    logic [AES_W-1:0]        cipher_q;
    logic [pCOUNT_WIDTH-1:0] target_q;
    logic [pCOUNT_WIDTH-1:0] runs_q;
    logic                    chain_q;

    logic start;
    logic accept;
    logic last;
    logic wdog_expire;

    cw305_start_detect u_start (
        .crypto_clk (crypto_clk),
        .reset_i    (reset_i),
        .go_reg     (go_reg_i),
        .go_trig    (go_trig_i),
        .start      (start)
    );

    assign accept = (state_q == IDLE) && start;

    // runs_q already counts the capture in progress once CAPTURE is reached
    assign last = (state_q == CAPTURE) && (runs_q == target_q);

`ifdef AES_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(pWDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_q;
    logic            error_q;

    always_ff @(posedge crypto_clk) begin
        if (reset_i || state_q != RUN) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign wdog_expire = (state_q == RUN) && !core_done_i &&
                         (wdog_q == WD_W'(pWDOG_CYCLES - 1));

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (wdog_expire) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    assign wdog_expire = (pWDOG_CYCLES < 0);
    assign error_o     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                if (core_done_i) begin
                    state_d = CAPTURE;
                end else if (wdog_expire) begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                state_d = last ? IDLE : LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q  <= IDLE;
            pt_q     <= '0;
            key_q    <= '0;
            cipher_q <= '0;
            target_q <= '0;
            runs_q   <= '0;
            chain_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pt_q     <= textin_i;
                key_q    <= key_i;
                chain_q  <= chain_i;
                runs_q   <= '0;
                target_q <= (batch_count_i == '0) ?
                            pCOUNT_WIDTH'(1) : batch_count_i;
            end
            // core_ct_i is only guaranteed valid alongside core_done_i
            if (state_q == RUN && core_done_i) begin
                cipher_q <= core_ct_i;
                runs_q   <= runs_q + 1'b1;
            end
            if (state_q == CAPTURE && chain_q) begin
                pt_q <= cipher_q;
            end
        end
    end

    assign core_load_o = (state_q == LOAD);
    assign trigger_o   = (state_q == RUN);
    assign core_pt_o   = pt_q;
    assign core_key_o  = key_q;
    assign cipherout_o = cipher_q;
    assign runs_o      = runs_q;
    assign done_o      = last;
    assign busy_o      = (state_q != IDLE) && !last;

endmodule

// File: tb/tb_cw305_aes_sequencer.sv
// Scoreboard bench for cw305_aes_sequencer with a behavioural AES core.
// Watchdog scenario runs when AES_SEQ_WATCHDOG_EN is defined.
module tb_cw305_aes_sequencer;

    localparam int CW = 16;

    localparam logic [127:0] VEC_KEY = 128'habcdef0112345678deadbeef87654321;
    localparam logic [127:0] VEC_PT  = 128'h12345678abcdef0187654321deadbeef;
    localparam logic [127:0] VEC_CT  = 128'h8a278bf8fa2812bc39e52c76205af377;

    logic           crypto_clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           go_reg_i = 1'b0;
    logic           go_trig_i = 1'b0;
    logic [127:0]   textin_i = '0;
    logic [127:0]   key_i = '0;
    logic [CW-1:0]  batch_count_i = '0;
    logic           chain_i = 1'b0;
    logic           core_load_o;
    logic [127:0]   core_pt_o;
    logic [127:0]   core_key_o;
    logic           core_done_i = 1'b0;
    logic [127:0]   core_ct_i = '0;
    logic [127:0]   cipherout_o;
    logic           busy_o;
    logic           done_o;
    logic           trigger_o;
    logic [CW-1:0]  runs_o;
    logic           error_o;

    always #5 crypto_clk = ~crypto_clk;

    cw305_aes_sequencer #(
        .pCOUNT_WIDTH (CW),
        .pWDOG_CYCLES (32)
    ) dut (
        .crypto_clk    (crypto_clk),
        .reset_i       (reset_i),
        .go_reg_i      (go_reg_i),
        .go_trig_i     (go_trig_i),
        .textin_i      (textin_i),
        .key_i         (key_i),
        .batch_count_i (batch_count_i),
        .chain_i       (chain_i),
        .core_load_o   (core_load_o),
        .core_pt_o     (core_pt_o),
        .core_key_o    (core_key_o),
        .core_done_i   (core_done_i),
        .core_ct_i     (core_ct_i),
        .cipherout_o   (cipherout_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .trigger_o     (trigger_o),
        .runs_o        (runs_o),
        .error_o       (error_o)
    );

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
    } ld_t;

    typedef struct {
        logic [127:0] ct;
        logic [CW-1:0] runs;
    } dn_t;

    typedef struct {
        string        name;
        logic [127:0] act;
        logic [127:0] exp;
    } ck_t;

    ld_t ld_q[$];
    dn_t dn_q[$];
    ck_t ck_q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [127:0] aes_f(logic [127:0] pt, logic [127:0] key);
        if (pt == VEC_PT && key == VEC_KEY) return VEC_CT;
        return {pt[95:0], pt[127:96]} ^ key ^ 128'h5a;
    endfunction

    // behavioural core: done three cycles after the load strobe
    logic         hang = 1'b0;
    bit           pend = 1'b0;
    int           lat = 0;
    logic [127:0] m_pt = '0;
    logic [127:0] m_key = '0;

    always @(negedge crypto_clk) begin
        core_done_i = 1'b0;
        if (reset_i) begin
            pend = 1'b0;
        end else if (core_load_o) begin
            pend  = 1'b1;
            lat   = 3;
            m_pt  = core_pt_o;
            m_key = core_key_o;
        end else if (pend && !hang) begin
            lat = lat - 1;
            if (lat == 0) begin
                pend        = 1'b0;
                core_done_i = 1'b1;
                core_ct_i   = aes_f(m_pt, m_key);
            end
        end
    end

    task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge crypto_clk) begin : monitor
        ld_t le;
        dn_t de;
        ck_t ce;
        if (core_load_o === 1'b1) begin
            if (ld_q.size() == 0) begin
                cmp("unexpected_load", 1, 0);
            end else begin
                le = ld_q.pop_front();
                cmp("load_pt", core_pt_o, le.pt);
                cmp("load_key", core_key_o, le.key);
            end
        end
        if (done_o === 1'b1) begin
            if (dn_q.size() == 0) begin
                cmp("unexpected_done", 1, 0);
            end else begin
                de = dn_q.pop_front();
                cmp("done_ct", cipherout_o, de.ct);
                cmp("done_runs", runs_o, de.runs);
                cmp("done_busy", busy_o, 0);
            end
        end
        while (ck_q.size() > 0) begin
            ce = ck_q.pop_front();
            cmp(ce.name, ce.act, ce.exp);
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge crypto_clk);
    endtask

    task automatic push_ck(string n, logic [127:0] a, logic [127:0] e);
        ck_t c;
        c.name = n;
        c.act  = a;
        c.exp  = e;
        ck_q.push_back(c);
    endtask

    task automatic push_ld(logic [127:0] pt, logic [127:0] key);
        ld_t l;
        l.pt  = pt;
        l.key = key;
        ld_q.push_back(l);
    endtask

    task automatic push_dn(logic [127:0] ct, logic [CW-1:0] runs);
        dn_t d;
        d.ct   = ct;
        d.runs = runs;
        dn_q.push_back(d);
    endtask

    task automatic go_pulse();
        go_reg_i = 1'b1;
        cyc(1);
        go_reg_i = 1'b0;
    endtask

    task automatic wait_idle(string n, int budget);
        int i;
        i = 0;
        while (busy_o !== 1'b0 && i < budget) begin
            cyc(1);
            i++;
        end
        if (i >= budget) push_ck({n, "_timeout"}, 0, 1);
        cyc(2);
    endtask

    task automatic wait_trig(string n, int budget);
        int i;
        i = 0;
        while (trigger_o !== 1'b1 && i < budget) begin
            cyc(1);
            i++;
        end
        if (i >= budget) push_ck({n, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [127:0] p;
        logic [127:0] k;
        logic [127:0] c1;
        logic [127:0] c2;
        int           tc;
        int           i;

        cyc(3);
        push_ck("rst_busy", busy_o, 0);
        push_ck("rst_done", done_o, 0);
        push_ck("rst_trig", trigger_o, 0);
        push_ck("rst_load", core_load_o, 0);
        push_ck("rst_ct", cipherout_o, 0);
        push_ck("rst_runs", runs_o, 0);
        push_ck("rst_err", error_o, 0);
        reset_i = 1'b0;
        cyc(2);

        // register start with the reference vector
        textin_i      = VEC_PT;
        key_i         = VEC_KEY;
        batch_count_i = 1;
        chain_i       = 1'b0;
        push_ld(VEC_PT, VEC_KEY);
        push_dn(VEC_CT, 1);
        go_pulse();
        push_ck("lat_load", core_load_o, 1);
        push_ck("lat_busy", busy_o, 1);
        cyc(1);
        push_ck("lat_trig", trigger_o, 1);
        wait_idle("t1", 50);
        push_ck("t1_busy_low", busy_o, 0);
        push_ck("t1_ct_held", cipherout_o, VEC_CT);

        // long trigger level gives exactly one run
        p = 128'h00112233445566778899aabbccddeeff;
        k = 128'h0f0e0d0c0b0a09080706050403020100;
        textin_i = p;
        key_i    = k;
        push_ld(p, k);
        push_dn(aes_f(p, k), 1);
        go_trig_i = 1'b1;
        cyc(10);
        go_trig_i = 1'b0;
        wait_idle("t2", 50);

        // chained batch of three; inputs disturbed after start
        p  = 128'hcafef00d_00000001_deadbeef_12345678;
        c1 = aes_f(p, k);
        c2 = aes_f(c1, k);
        textin_i      = p;
        batch_count_i = 3;
        chain_i       = 1'b1;
        push_ld(p, k);
        push_ld(c1, k);
        push_ld(c2, k);
        push_dn(aes_f(c2, k), 3);
        go_pulse();
        textin_i      = ~p;
        key_i         = '0;
        chain_i       = 1'b0;
        batch_count_i = 7;
        wait_idle("t3", 100);
        push_ck("t3_runs", runs_o, 3);

        // batch of zero behaves as one
        p = 128'h11111111_22222222_33333333_44444444;
        k = 128'h55555555_66666666_77777777_88888888;
        textin_i      = p;
        key_i         = k;
        batch_count_i = 0;
        chain_i       = 1'b0;
        push_ld(p, k);
        push_dn(aes_f(p, k), 1);
        go_pulse();
        wait_idle("t4a", 50);

        // four unchained runs reuse the same plaintext
        batch_count_i = 4;
        for (int j = 0; j < 4; j++) push_ld(p, k);
        push_dn(aes_f(p, k), 4);
        go_pulse();
        wait_idle("t4b", 100);
        push_ck("t4b_runs", runs_o, 4);

        // simultaneous sources, then a dropped mid-run GO
        batch_count_i = 1;
        push_ld(p, k);
        push_dn(aes_f(p, k), 1);
        go_reg_i  = 1'b1;
        go_trig_i = 1'b1;
        cyc(1);
        go_reg_i = 1'b0;
        wait_trig("t5", 20);
        go_pulse();
        wait_idle("t5", 50);
        go_trig_i = 1'b0;
        cyc(2);
        push_ck("t5_runs", runs_o, 1);
        push_ck("t5_busy", busy_o, 0);

        // reset in the middle of a batch of five
        batch_count_i = 5;
        push_ld(p, k);
        go_pulse();
        wait_trig("t6", 20);
        reset_i = 1'b1;
        cyc(1);
        push_ck("t6_busy", busy_o, 0);
        push_ck("t6_trig", trigger_o, 0);
        push_ck("t6_load", core_load_o, 0);
        push_ck("t6_done", done_o, 0);
        push_ck("t6_runs", runs_o, 0);
        push_ck("t6_ct", cipherout_o, 0);
        push_ck("t6_pt", core_pt_o, 0);
        cyc(1);
        reset_i = 1'b0;
        cyc(8);
        push_ck("t6_idle", busy_o, 0);

`ifdef AES_SEQ_WATCHDOG_EN
        hang          = 1'b1;
        batch_count_i = 1;
        push_ld(p, k);
        go_pulse();
        tc = 0;
        i  = 0;
        while (busy_o === 1'b1 && i < 200) begin
            if (trigger_o === 1'b1) tc++;
            cyc(1);
            i++;
        end
        if (i >= 200) push_ck("wd_timeout", 0, 1);
        push_ck("wd_run_cycles", tc, 32);
        push_ck("wd_error", error_o, 1);
        push_ck("wd_busy", busy_o, 0);
        push_ck("wd_trig", trigger_o, 0);
        push_ck("wd_ct", cipherout_o, 0);
        cyc(3);
        push_ck("wd_sticky", error_o, 1);
        hang = 1'b0;
        push_ld(p, k);
        push_dn(aes_f(p, k), 1);
        go_pulse();
        push_ck("wd_clear", error_o, 0);
        wait_idle("wd_after", 50);
`else
        push_ck("err_tied", error_o, 0);
`endif

        push_ck("ld_q_empty", ld_q.size(), 0);
        push_ck("dn_q_empty", dn_q.size(), 0);
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cw305_aes_sequencer.md
Name: cw305_aes_sequencer

Overview:
- Sequences the 128-bit AES core in the crypto clock domain; sits between the CW305 register block and the AES core.
- Merges two start sources: the register GO bit and the synchronized usb_trigger level. Runs 1..N back-to-back encryptions per start, optionally chaining each ciphertext into the next plaintext.
- Captures the ciphertext and drives busy/done/trigger status for readback and the scope trigger.

Parameters:
pCOUNT_WIDTH, 16, width of batch count and internal encryption counter
pWDOG_CYCLES, 1024, watchdog limit in crypto_clk cycles (used only with the optional feature)

Ports:
crypto_clk  in  1  crypto clock; all logic on rising edge
reset_i  in  1  synchronous, active-high reset
go_reg_i  in  1  one-cycle start pulse from register block (already synchronized)
go_trig_i  in  1  usb_trigger level (already synchronized); rising edge starts
textin_i  in  128  plaintext from register block
key_i  in  128  key from register block
batch_count_i  in  pCOUNT_WIDTH  encryptions per start; 0 treated as 1
chain_i  in  1  1: ciphertext of run k is plaintext of run k+1
core_load_o  out  1  one-cycle load/start strobe to AES core
core_pt_o  out  128  plaintext presented to core
core_key_o  out  128  key presented to core
core_done_i  in  1  one-cycle done pulse from core
core_ct_i  in  128  ciphertext, valid when core_done_i=1
cipherout_o  out  128  last captured ciphertext
busy_o  out  1  high from accepted start until final capture
done_o  out  1  one-cycle pulse after final capture of a batch
trigger_o  out  1  high while the core is computing (scope trigger)
runs_o  out  pCOUNT_WIDTH  encryptions completed in the current/last batch
error_o  out  1  sticky watchdog error (0 when feature compiled out)

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0; cipherout_o=0; runs_o=0. Reset mid-batch aborts immediately. No done_o pulse. Core outputs are deasserted.
- Start detection: start = go_reg_i | (go_trig_i & ~go_trig_q), where go_trig_q is registered go_trig_i.
  - Simultaneous reg and trig starts count as one start.
  - A trigger held high for many cycles gives one start.
  - Starts seen while busy_o=1 are dropped; they are not queued.
- States:
  - IDLE: on start, latch key_i and textin_i into pt/key registers, latch max(batch_count_i,1) into target, clear runs_o, set busy_o, go to LOAD.
  - LOAD: core_load_o=1 for exactly one cycle; then go to RUN.
  - RUN: trigger_o=1. On core_done_i, go to CAPTURE.
  - CAPTURE (1 cycle):
    - cipherout_o<=core_ct_i; runs_o<=runs_o+1.
    - If chain_i, pt<=core_ct_i.
    - If runs_o+1==target: go to IDLE, busy_o<=0, done_o pulses the same cycle busy falls.
    - Else go to LOAD.
- Latency: start cycle S gives core_load_o at S+1 and trigger_o high from S+2. done_o comes 1 cycle after core_done_i.
- core_pt_o and core_key_o are stable from LOAD through CAPTURE. textin_i and key_i changes during a batch have no effect.
- chain_i and batch_count_i are sampled only at start.
- runs_o wraps naturally at 2^pCOUNT_WIDTH; target never exceeds 2^pCOUNT_WIDTH-1.
- core_done_i outside RUN is ignored.
- Clock gating on the USB side is irrelevant here: the block is purely crypto_clk. The register GO status reads busy_o.

Optional Feature:
- Macro AES_SEQ_WATCHDOG_EN.
- Defined: in RUN, a counter counts cycles. If it reaches pWDOG_CYCLES without core_done_i:
  - go to IDLE and set error_o=1 (sticky until reset_i or the next accepted start);
  - busy_o=0 and trigger_o=0;
  - no done_o pulse; cipherout_o unchanged.
- Not defined: no counter; error_o tied 0; RUN waits indefinitely.

Decomposition:
- Shared package cw305_aes_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, CAPTURE);
  - AES width constant 128;
  - default pCOUNT_WIDTH and pWDOG_CYCLES.
- One natural sub-module: cw305_start_detect (trigger edge detect plus OR with register pulse).

Test Plan:
- Register start: key=abcdef0112345678deadbeef87654321, pt=12345678abcdef0187654321deadbeef, batch=1, go_reg_i pulse -> one core_load_o; cipherout_o=8a278bf8fa2812bc39e52c76205af377; done_o pulses once; busy_o low after.
- Trigger start: go_trig_i held high 10 cycles, batch=1 -> exactly one encryption; no second load after the core finishes while the trigger is still high.
- Batch chain: batch=3, chain_i=1, fixed pt -> 3 loads; each core_pt_o equals the previous core_ct_i; runs_o=3; single done_o.
- Batch no-chain: batch=0 -> treated as 1. Then batch=4, chain_i=0 -> 4 loads, all with the identical pt.
- Collision/busy: go_reg_i and a trigger edge in the same cycle -> one start. A go_reg_i pulse mid-RUN is ignored (load count unchanged).
- Reset and watchdog:
  - reset_i during RUN of batch=5 -> next cycle IDLE; outputs 0; no done_o.
  - With AES_SEQ_WATCHDOG_EN and the core never asserting done, pWDOG_CYCLES=32 -> error_o=1 after 32 RUN cycles and busy_o=0.
